// File: rtl/credits_pkg.sv
// Shared definitions for the credits screen: FSM states, colours, default
// timing, the credit text lines and the glyph ROM geometry.
// Port summary: package only, no ports.
package credits_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FADE_IN,
    ST_SCROLL,
    ST_HOLD,
    ST_FADE_OUT
  } state_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t BG_RGB   = '{r: 3'd7, g: 3'd0, b: 2'd3};
  localparam rgb_t TEXT_RGB = '{r: 3'd7, g: 3'd7, b: 2'd3};

  localparam int DEF_H_ACTIVE         = 640;
  localparam int DEF_V_ACTIVE         = 480;
  localparam int DEF_CHAR_W           = 8;
  localparam int DEF_CHAR_H           = 16;
  localparam int DEF_TEXT_ROWS        = 8;
  localparam int DEF_TEXT_COLS        = 32;
  localparam int DEF_SCROLL_DIV       = 2;
  localparam int DEF_FADE_STEP_FRAMES = 4;
  localparam int DEF_HOLD_FRAMES      = 120;

  // Glyph ROM holds 128 character codes, CHAR_H rows each.
  localparam int GLYPH_CODES = 128;
  localparam int GLYPH_DEPTH = GLYPH_CODES * DEF_CHAR_H;

  // Stored width of each credit line; columns beyond it read as blank.
  localparam int TEXT_LINE_CHARS = 32;

  // Each line is built from four 8-character groups so the width is exact.
  function automatic logic [8*TEXT_LINE_CHARS-1:0] text_line(input int unsigned idx);
    case (idx)
      0:       return {"========", "========", "========", "========"};
      1:       return {"        ", "CREDITS ", "        ", "        "};
      3:       return {"DESIGN  ", "        ", "  A. DEV", "ELOPER  "};
      4:       return {"ART     ", "        ", "  B. PIX", "EL      "};
      5:       return {"MUSIC   ", "        ", "  C. NOT", "E       "};
      7:       return {"THANKS F", "OR PLAYI", "NG      ", "========"};
      default: return {"        ", "        ", "        ", "        "};
    endcase
  endfunction

  // Brightness limit: each channel is clipped to the current level
  // (blue has half the range, so it is clipped to level>>1).
  function automatic rgb_t scale_rgb(input rgb_t base, input logic [2:0] level);
    rgb_t       o;
    logic [1:0] lvl_b;
    lvl_b = level[2:1];
    o.r   = (base.r < level) ? base.r : level;
    o.g   = (base.g < level) ? base.g : level;
    o.b   = (base.b < lvl_b) ? base.b : lvl_b;
    return o;
  endfunction

endpackage

// File: rtl/credits_glyph_rom.sv
// Text ROM (char code per row/col) feeding a glyph ROM; one registered read.
// Ports: clk_i/rst_ni; text_row_i/text_col_i select the character cell,
//   glyph_row_i/glyph_col_i select the pixel inside it; glyph_bit_o one cycle later.
module credits_glyph_rom
  import credits_pkg::*;
#(
  parameter int TEXT_ROWS = DEF_TEXT_ROWS,
  parameter int TEXT_COLS = DEF_TEXT_COLS,
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int CHAR_H    = DEF_CHAR_H
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [$clog2(TEXT_ROWS)-1:0] text_row_i,
  input  logic [$clog2(TEXT_COLS)-1:0] text_col_i,
  input  logic [$clog2(CHAR_H)-1:0]    glyph_row_i,
  input  logic [$clog2(CHAR_W)-1:0]    glyph_col_i,
  output logic                         glyph_bit_o
);

  localparam int GR_W = $clog2(CHAR_H);
  localparam int GC_W = $clog2(CHAR_W);
  localparam logic [GC_W-1:0] LAST_COL = GC_W'(CHAR_W - 1);

  logic [8*TEXT_LINE_CHARS-1:0] line;
  logic [6:0]                   code;
  logic [7+GR_W-1:0]            glyph_addr;
  logic [CHAR_W-1:0]            row_bits;
  logic                         glyph_bit_q;

  // Procedural font: codes up to and including space are empty, every other
  // printable code renders as an outlined cell.
  function automatic logic [CHAR_W-1:0] glyph_word(input logic [7+GR_W-1:0] addr);
    logic [6:0]        c;
    logic [GR_W-1:0]   r;
    logic [CHAR_W-1:0] bits;
    c    = addr[7+GR_W-1:GR_W];
    r    = addr[GR_W-1:0];
    bits = '0;
    if (c > 7'h20) begin
      if (r == '0 || r == GR_W'(CHAR_H - 1)) begin
        bits = '1;
      end else begin
        bits[0]        = 1'b1;
        bits[CHAR_W-1] = 1'b1;
      end
    end
    return bits;
  endfunction

  always_comb begin
    line = text_line(int'(text_row_i));
    code = 7'h20;
    if (int'(text_col_i) < TEXT_LINE_CHARS) begin
      // Column 0 is the first character, i.e. the most significant byte.
      code = line[(TEXT_LINE_CHARS - 1 - int'(text_col_i)) * 8 +: 7];
    end
    glyph_addr = {code, glyph_row_i};
    row_bits   = glyph_word(glyph_addr);
  end

  // Bit CHAR_W-1 of a glyph row is the leftmost pixel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glyph_bit_q <= 1'b0;
    end else begin
      glyph_bit_q <= row_bits[LAST_COL - glyph_col_i];
    end
  end

  assign glyph_bit_o = glyph_bit_q;

endmodule

// File: rtl/credits_scroller.sv
// Animated credits screen: fade in, scroll text up, hold, fade out, done.
// Ports: clk_i/rst_ni; start_i, frame_tick_i; xpos_i/ypos_i -> red_o/green_o/blue_o
//   (2-cycle latency); busy_o (not IDLE), done_o (1-cycle pulse at end).
// Build option CREDITS_LOOP_EN: replay the sequence forever instead of idling.
module credits_scroller
  import credits_pkg::*;
#(
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int CHAR_W           = DEF_CHAR_W,
  parameter int CHAR_H           = DEF_CHAR_H,
  parameter int TEXT_ROWS        = DEF_TEXT_ROWS,
  parameter int TEXT_COLS        = DEF_TEXT_COLS,
  parameter int SCROLL_DIV       = DEF_SCROLL_DIV,
  parameter int FADE_STEP_FRAMES = DEF_FADE_STEP_FRAMES,
  parameter int HOLD_FRAMES      = DEF_HOLD_FRAMES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       frame_tick_i,
  input  logic [9:0] xpos_i,
  input  logic [9:0] ypos_i,
  output logic [2:0] red_o,
  output logic [2:0] green_o,
  output logic [1:0] blue_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int TEXT_H        = TEXT_ROWS * CHAR_H;
  localparam int TEXT_W        = TEXT_COLS * CHAR_W;
  localparam int X0            = (H_ACTIVE - TEXT_W) / 2;
  localparam int SCROLL_TARGET = (V_ACTIVE - TEXT_H) / 2;
  localparam int ROW_W         = $clog2(TEXT_ROWS);
  localparam int COL_W         = $clog2(TEXT_COLS);
  localparam int GR_W          = $clog2(CHAR_H);
  localparam int GC_W          = $clog2(CHAR_W);
  localparam int CNT_W         = 16;

  localparam logic [9:0]       SCROLL_START = 10'(V_ACTIVE);
  localparam logic [9:0]       LAST_STEP_Y  = 10'(SCROLL_TARGET + 1);
  localparam logic [CNT_W-1:0] FADE_LAST    = CNT_W'(FADE_STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] SCROLL_LAST  = CNT_W'(SCROLL_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_FRAMES - 1);

  // ---------------------------------------------------------------- FSM
  state_e           state_q;
  logic [2:0]       level_q;
  logic [9:0]       scroll_y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      level_q    <= 3'd7;
      scroll_y_q <= SCROLL_START;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        // start has priority over a coincident frame tick; that tick is dropped.
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_FADE_IN;
            level_q    <= 3'd0;
            scroll_y_q <= SCROLL_START;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        ST_FADE_IN: begin
          if (frame_tick_i) begin
            if (cnt_q == FADE_LAST) begin
              cnt_q   <= '0;
              level_q <= level_q + 3'd1;
              if (level_q == 3'd6) state_q <= ST_SCROLL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_SCROLL: begin
          if (frame_tick_i) begin
            if (cnt_q == SCROLL_LAST) begin
              cnt_q      <= '0;
              scroll_y_q <= scroll_y_q - 10'd1;
              // The step landing on the target is the last one.
              if (scroll_y_q == LAST_STEP_Y) state_q <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (frame_tick_i) begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_FADE_OUT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FADE_OUT: begin
          if (frame_tick_i) begin
            if (cnt_q == FADE_LAST) begin
              cnt_q <= '0;
              if (level_q == 3'd1) begin
                done_q <= 1'b1;
`ifdef CREDITS_LOOP_EN
                state_q    <= ST_FADE_IN;
                level_q    <= 3'd0;
                scroll_y_q <= SCROLL_START;
`else
                state_q <= ST_IDLE;
                level_q <= 3'd7;
                busy_q  <= 1'b0;
`endif
              end else begin
                level_q <= level_q - 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  // ---------------------------------------------------------------- stage 1
  logic signed [10:0] ty, tx;
  logic               in_win_d, blank_d;
  logic [ROW_W-1:0]   text_row_d;
  logic [COL_W-1:0]   text_col_d;
  logic [GR_W-1:0]    glyph_row_d;
  logic [GC_W-1:0]    glyph_col_d;

  always_comb begin
    // ty goes negative while the text block is still below the pixel.
    ty          = $signed({1'b0, ypos_i}) - $signed({1'b0, scroll_y_q});
    tx          = $signed({1'b0, xpos_i}) - $signed(11'(X0));
    in_win_d    = !ty[10] && (ty[9:0] < 10'(TEXT_H)) &&
                  !tx[10] && (tx[9:0] < 10'(TEXT_W)) &&
                  (state_q != ST_IDLE);
    blank_d     = (xpos_i >= 10'(H_ACTIVE)) || (ypos_i >= 10'(V_ACTIVE));
    text_row_d  = ROW_W'(ty[9:0] / 10'(CHAR_H));
    glyph_row_d = GR_W'(ty[9:0] % 10'(CHAR_H));
    text_col_d  = COL_W'(tx[9:0] / 10'(CHAR_W));
    glyph_col_d = GC_W'(tx[9:0] % 10'(CHAR_W));
  end

  logic             blank1_q, win1_q;
  logic [2:0]       level1_q;
  logic [ROW_W-1:0] text_row1_q;
  logic [COL_W-1:0] text_col1_q;
  logic [GR_W-1:0]  glyph_row1_q;
  logic [GC_W-1:0]  glyph_col1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blank1_q     <= 1'b1;
      win1_q       <= 1'b0;
      level1_q     <= 3'd0;
      text_row1_q  <= '0;
      text_col1_q  <= '0;
      glyph_row1_q <= '0;
      glyph_col1_q <= '0;
    end else begin
      blank1_q     <= blank_d;
      win1_q       <= in_win_d;
      level1_q     <= level_q;
      text_row1_q  <= text_row_d;
      text_col1_q  <= text_col_d;
      glyph_row1_q <= glyph_row_d;
      glyph_col1_q <= glyph_col_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic glyph_bit;

  credits_glyph_rom #(
    .TEXT_ROWS (TEXT_ROWS),
    .TEXT_COLS (TEXT_COLS),
    .CHAR_W    (CHAR_W),
    .CHAR_H    (CHAR_H)
  ) u_rom (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .text_row_i  (text_row1_q),
    .text_col_i  (text_col1_q),
    .glyph_row_i (glyph_row1_q),
    .glyph_col_i (glyph_col1_q),
    .glyph_bit_o (glyph_bit)
  );

  // Both candidate colours are scaled alongside the ROM read so the final
  // select only needs the glyph bit.
  logic blank2_q, win2_q;
  rgb_t bg2_q, txt2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blank2_q <= 1'b1;
      win2_q   <= 1'b0;
      bg2_q    <= '0;
      txt2_q   <= '0;
    end else begin
      blank2_q <= blank1_q;
      win2_q   <= win1_q;
      bg2_q    <= scale_rgb(BG_RGB, level1_q);
      txt2_q   <= scale_rgb(TEXT_RGB, level1_q);
    end
  end

  rgb_t pix;

  always_comb begin
    pix = bg2_q;
    if (blank2_q)                  pix = '0;
    else if (win2_q && glyph_bit)  pix = txt2_q;
  end

  assign red_o   = pix.r;
  assign green_o = pix.g;
  assign blue_o  = pix.b;

endmodule

// File: tb/tb_credits_scroller.sv
module tb_credits_scroller;

  localparam int SD = 1;
  localparam int FS = 1;
  localparam int HF = 2;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam int X0 = (HA - 32 * 8) / 2;          // 192
  localparam int TARGET = (VA - 8 * 16) / 2;      // 176
  localparam int FI = 7 * FS;
  localparam int SC = (VA - TARGET) * SD;         // 304
  localparam int HO = HF;
  localparam int FO = 7 * FS;
  localparam int TOTAL = FI + SC + HO + FO;

  logic       clk = 1'b0;
  logic       rst_n, start, frame_tick;
  logic [9:0] xpos, ypos;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       busy, done;

  always #5 clk = ~clk;

  credits_scroller #(
    .SCROLL_DIV       (SD),
    .FADE_STEP_FRAMES (FS),
    .HOLD_FRAMES      (HF)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .frame_tick_i (frame_tick),
    .xpos_i       (xpos),
    .ypos_i       (ypos),
    .red_o        (red),
    .green_o      (green),
    .blue_o       (blue),
    .busy_o       (busy),
    .done_o       (done)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  string txt [8];

  always @(negedge clk) if (done) done_cnt++;

  function automatic int rgb(int r, int g, int b);
    return r * 32 + g * 4 + b;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int pix();
    return int'({red, green, blue});
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline after start, in frame ticks.
  function automatic int m_level(int n);
    if (n < FI) return n / FS;
    if (n < FI + SC + HO) return 7;
    if (n < TOTAL) return 7 - (n - FI - SC - HO) / FS;
    return 7;
  endfunction

  function automatic int m_sy(int n);
    if (n < FI) return VA;
    if (n < FI + SC) return VA - (n - FI) / SD;
    return TARGET;
  endfunction

  // Text lines are drawn as outlined cells for every non-space character.
  function automatic int model_rgb(int x, int y, int lvl, int sy, bit active);
    int  ty, tx, row, col, gr, gc;
    bit  is_text;
    byte ch;
    if (x >= HA || y >= VA) return 0;
    is_text = 1'b0;
    ty = y - sy;
    tx = x - X0;
    if (active && ty >= 0 && ty < 128 && tx >= 0 && tx < 256) begin
      row = ty / 16; col = tx / 8; gr = ty % 16; gc = tx % 8;
      ch = txt[row][col];
      if (ch != " " && (gr == 0 || gr == 15 || gc == 0 || gc == 7)) is_text = 1'b1;
    end
    return rgb(imin(7, lvl), imin(is_text ? 7 : 0, lvl), imin(3, lvl / 2));
  endfunction

  task automatic probe(string name, int x, int y, int exp);
    xpos = 10'(x);
    ypos = 10'(y);
    repeat (2) @(posedge clk);
    #1;
    check(name, pix(), exp);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct {
    int    x;
    int    y;
    int    exp;
    string name;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n, x, y, sy;

    txt[0] = {"========", "========", "========", "========"};
    txt[1] = {"        ", "CREDITS ", "        ", "        "};
    txt[2] = {"        ", "        ", "        ", "        "};
    txt[3] = {"DESIGN  ", "        ", "  A. DEV", "ELOPER  "};
    txt[4] = {"ART     ", "        ", "  B. PIX", "EL      "};
    txt[5] = {"MUSIC   ", "        ", "  C. NOT", "E       "};
    txt[6] = {"        ", "        ", "        ", "        "};
    txt[7] = {"THANKS F", "OR PLAYI", "NG      ", "========"};

    vecs[0] = '{100, 100, rgb(7, 0, 3), "idle_bg"};
    vecs[1] = '{700, 100, 0,            "idle_blank_x"};
    vecs[2] = '{100, 480, 0,            "idle_blank_y"};
    vecs[3] = '{639, 479, rgb(7, 0, 3), "idle_last_pixel"};
    vecs[4] = '{640, 0,   0,            "idle_x_edge"};
    vecs[5] = '{0,   0,   rgb(7, 0, 3), "idle_origin"};
    vecs[6] = '{X0,  176, rgb(7, 0, 3), "idle_no_text"};
    vecs[7] = '{300, 500, 0,            "idle_blank_xy"};
    vecs[8] = '{1023, 1023, 0,          "idle_max"};
    vecs[9] = '{X0 + 255, 479, rgb(7, 0, 3), "idle_right_edge"};

    rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0; xpos = 10'd100; ypos = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", pix(), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) probe(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].exp);
    check("idle_busy", int'(busy), 0);

    // start and frame_tick together: start wins, the tick is dropped.
    start = 1'b1; frame_tick = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; frame_tick = 1'b0;
    check("start_busy", int'(busy), 1);
    probe("start_tick_level0", 100, 100, 0);
    n = 0;

    while (n < TOTAL) begin
      tick();
      n++;
      if (n == TOTAL) begin
        check("done_pulse", int'(done), 1);
        check("busy_fall", int'(busy), 0);
        @(posedge clk);
        #1;
        check("done_width", int'(done), 0);
      end else begin
        check("done_low", int'(done), 0);
        check("busy_high", int'(busy), 1);
      end
      if (n <= FI)
        probe("fade_in_bg", 100, 100, model_rgb(100, 100, m_level(n), m_sy(n), n < TOTAL));
      if (n == 1) probe("fade_in_first", 100, 100, rgb(1, 0, 0));
      if (n == FI) probe("fade_in_full", 100, 100, rgb(7, 0, 3));
      if (n == FI + 100) begin
        pulse_start();
        check("start_ignored_busy", int'(busy), 1);
        probe("start_ignored_level", 100, 100, rgb(7, 0, 3));
      end
      if (n == FI + SC) begin
        probe("hold_text_pixel", X0, TARGET, rgb(7, 7, 3));
        probe("hold_above_window", X0, TARGET - 1, rgb(7, 0, 3));
      end
      for (int k = 0; k < 2; k++) begin
        sy = m_sy(n);
        if ($urandom_range(0, 1) == 1) y = imin(1023, sy - 8 + int'($urandom_range(0, 143)));
        else y = int'($urandom_range(0, 520));
        if ($urandom_range(0, 1) == 1) x = int'($urandom_range(X0 - 8, X0 + 264));
        else x = int'($urandom_range(0, 800));
        probe("random_pixel", x, y, model_rgb(x, y, m_level(n), sy, n < TOTAL));
      end
    end

    check("done_count", done_cnt, 1);
    probe("after_idle_no_text", X0, TARGET, rgb(7, 0, 3));
    probe("after_idle_level", 100, 100, rgb(7, 0, 3));

    // Second pass, reset while scrolling.
    pulse_start();
    for (int i = 0; i < FI + 50; i++) tick();
    probe("mid_scroll_pixel", 100, 100, rgb(7, 0, 3));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", pix(), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_no_done", done_cnt, 1);
    probe("midrst_idle_bg", 100, 100, rgb(7, 0, 3));
    check("midrst_idle_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
